// File: rtl/ps2if.sv
// PS/2 keyboard receiver: synchronizes the PS/2 pins, deframes 11-bit frames into a 16-deep FIFO.
// Optional PS2IF_GLITCH_FILTER_EN adds a 4-sample stability filter on the synchronized PS/2 clock.
module ps2if #(
  parameter int FIFO_AW = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IO_Address,
  input  logic [31:0] IO_Write_Data,
  input  logic        WR,
  output logic [31:0] RDATA,
  input  logic        PS2CLK,
  input  logic        PS2DATA
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic clk_s1, clk_s2, dat_s1, dat_s2, clk_prev, clk_lvl, fall;

  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_prev <= 1'b1;
    end else begin
      clk_s1   <= PS2CLK;
      clk_s2   <= clk_s1;
      dat_s1   <= PS2DATA;
      dat_s2   <= dat_s1;
      clk_prev <= clk_lvl;
    end
  end

`ifdef PS2IF_GLITCH_FILTER_EN
  logic [2:0] clk_hist;
  logic       clk_filt;

  // Level follows the synchronized clock only after four equal samples in a row.
  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_hist <= '1;
      clk_filt <= 1'b1;
    end else begin
      clk_hist <= {clk_hist[1:0], clk_s2};
      if ({clk_hist, clk_s2} == 4'b0000)
        clk_filt <= 1'b0;
      else if ({clk_hist, clk_s2} == 4'b1111)
        clk_filt <= 1'b1;
    end
  end

  assign clk_lvl = clk_filt;
`else
  assign clk_lvl = clk_s2;
`endif

  assign fall = clk_prev & ~clk_lvl;

  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          timeout_hit;

  assign timeout_hit = (state != S_IDLE) && !fall && (tcnt == TW'(TIMEOUT));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else if (state == S_IDLE) begin
      tcnt <= '0;
      if (fall && !dat_s2) begin
        state   <= S_DATA;
        bit_cnt <= '0;
      end
    end else if (fall) begin
      tcnt <= '0;
      case (state)
        S_DATA: begin
          shreg   <= {dat_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state <= S_PARITY;
        end
        S_PARITY: begin
          par_bit <= dat_s2;
          state   <= S_STOP;
        end
        default: state <= S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state <= S_IDLE;
      tcnt  <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  logic frame_end, parity_ok, push, ferr_set, perr_set;

  // The STOP edge is judged combinationally so the byte lands in the FIFO on that same edge.
  always_comb begin
    frame_end = fall && (state == S_STOP);
    parity_ok = ^{shreg, par_bit};
    push      = frame_end && dat_s2 && parity_ok;
    perr_set  = frame_end && dat_s2 && !parity_ok;
    ferr_set  = (frame_end && !dat_s2) || timeout_hit;
  end

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty, pop, wr_en, ovf_set;
  logic               ovf, perr, ferr;
  logic               clr_ovf, clr_perr, clr_ferr;

  always_comb begin
    full     = (count == (FIFO_AW + 1)'(DEPTH));
    empty    = (count == '0);
    pop      = WR && !IO_Address[2] && !empty;
    wr_en    = push && (!full || pop);
    ovf_set  = push && full && !pop;
    clr_ovf  = WR && IO_Address[2] && IO_Write_Data[8];
    clr_perr = WR && IO_Address[2] && IO_Write_Data[9];
    clr_ferr = WR && IO_Address[2] && IO_Write_Data[10];
  end

  always_ff @(posedge CLK) begin
    if (wr_en)
      mem[wptr] <= shreg;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      if (wr_en)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ovf  <= ovf_set  | (ovf  & ~clr_ovf);
      perr <= perr_set | (perr & ~clr_perr);
      ferr <= ferr_set | (ferr & ~clr_ferr);
    end
  end

  always_comb begin
    RDATA = '0;
    if (!IO_Address[2]) begin
      RDATA[8]   = !empty;
      RDATA[7:0] = empty ? 8'h00 : mem[rptr];
    end else begin
      RDATA[FIFO_AW:0] = count;
      RDATA[10:8]      = {ferr, perr, ovf};
    end
  end

  logic unused_ok;
  assign unused_ok = ^{IO_Address[31:3], IO_Address[1:0],
                       IO_Write_Data[31:11], IO_Write_Data[7:0]};

endmodule

// File: tb/tb_ps2if.sv
// Directed self-checking bench for ps2if; PS/2 bit rate and timeout are scaled down to keep runs short.
module tb_ps2if;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IO_Address = '0;
  logic [31:0] IO_Write_Data = '0;
  logic        WR = 1'b0;
  logic [31:0] RDATA;
  logic        PS2CLK = 1'b1;
  logic        PS2DATA = 1'b1;

  int checks = 0;
  int errors = 0;

  ps2if #(.FIFO_AW(4), .TIMEOUT(200)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .IO_Address    (IO_Address),
    .IO_Write_Data (IO_Write_Data),
    .WR            (WR),
    .RDATA         (RDATA),
    .PS2CLK        (PS2CLK),
    .PS2DATA       (PS2DATA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_reg(input string tag, input logic a2, input logic [31:0] exp);
    @(negedge CLK);
    IO_Address = {29'd0, a2, 2'b00};
    #1;
    check(tag, RDATA, exp);
  endtask

  task automatic bus_wr(input logic a2, input logic [31:0] d);
    @(negedge CLK);
    IO_Address    = {29'd0, a2, 2'b00};
    IO_Write_Data = d;
    WR            = 1'b1;
    @(negedge CLK);
    WR            = 1'b0;
    IO_Write_Data = '0;
  endtask

  // Sends the first nbits of a frame; optionally pops DATA on the exact cycle the stop edge is consumed.
  task automatic ps2_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                           input int nbits, input logic pop_at_stop);
    logic [10:0] f;
    f = {stop, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2DATA = f[i];
      wait_n(10);
      PS2CLK = 1'b0;
      if (pop_at_stop && i == 10) begin
        wait_n(2);
        IO_Address = '0;
        WR = 1'b1;
        wait_n(1);
        WR = 1'b0;
        wait_n(17);
      end else begin
        wait_n(20);
      end
      PS2CLK = 1'b1;
      wait_n(10);
    end
    PS2DATA = 1'b1;
    wait_n(5);
  endtask

  task automatic send(input logic [7:0] d);
    ps2_frame(d, 1'b0, 1'b1, 11, 1'b0);
  endtask

  initial begin
    wait_n(4);
    RST = 1'b0;
    check_reg("rst_data", 1'b0, 32'h0000_0000);
    check_reg("rst_status", 1'b1, 32'h0000_0000);

    // Pop while empty has no effect
    bus_wr(1'b0, 32'h0);
    check_reg("empty_pop_status", 1'b1, 32'h0000_0000);

    send(8'h1C);
    check_reg("rx1c_data", 1'b0, 32'h0000_011C);
    check_reg("rx1c_status", 1'b1, 32'h0000_0001);
    bus_wr(1'b0, 32'h0);
    check_reg("rx1c_pop_data", 1'b0, 32'h0000_0000);

    ps2_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    check_reg("perr_status", 1'b1, 32'h0000_0200);
    check_reg("perr_data", 1'b0, 32'h0000_0000);
    bus_wr(1'b1, 32'h200);
    check_reg("perr_clr", 1'b1, 32'h0000_0000);

    for (int i = 1; i <= 17; i++) send(8'(i));
    check_reg("ovf_status", 1'b1, 32'h0000_0110);
    check_reg("ovf_head", 1'b0, 32'h0000_0101);
    for (int i = 1; i <= 16; i++) begin
      check_reg("ovf_drain", 1'b0, 32'h100 | 32'(i));
      bus_wr(1'b0, 32'h0);
    end
    check_reg("ovf_drained", 1'b0, 32'h0000_0000);
    bus_wr(1'b1, 32'h100);
    check_reg("ovf_clr", 1'b1, 32'h0000_0000);

    for (int i = 0; i < 16; i++) send(8'h20 + 8'(i));
    check_reg("full_status", 1'b1, 32'h0000_0010);
    ps2_frame(8'h55, 1'b0, 1'b1, 11, 1'b1);
    check_reg("pushpop_status", 1'b1, 32'h0000_0010);
    for (int i = 1; i < 16; i++) begin
      check_reg("pushpop_drain", 1'b0, 32'h120 + 32'(i));
      bus_wr(1'b0, 32'h0);
    end
    check_reg("pushpop_last", 1'b0, 32'h0000_0155);
    bus_wr(1'b0, 32'h0);
    check_reg("pushpop_empty", 1'b1, 32'h0000_0000);

    ps2_frame(8'h33, 1'b0, 1'b0, 11, 1'b0);
    check_reg("stop0_status", 1'b1, 32'h0000_0400);
    bus_wr(1'b1, 32'h400);
    ps2_frame(8'h33, 1'b1, 1'b0, 11, 1'b0);
    check_reg("both_err_status", 1'b1, 32'h0000_0400);
    bus_wr(1'b1, 32'h700);
    check_reg("both_err_clr", 1'b1, 32'h0000_0000);

    ps2_frame(8'hFF, 1'b0, 1'b1, 6, 1'b0);
    check_reg("partial_no_timeout", 1'b1, 32'h0000_0000);
    wait_n(300);
    check_reg("timeout_status", 1'b1, 32'h0000_0400);
    bus_wr(1'b1, 32'h400);
    send(8'h29);
    check_reg("after_timeout_data", 1'b0, 32'h0000_0129);
    check_reg("after_timeout_status", 1'b1, 32'h0000_0001);

    ps2_frame(8'hA5, 1'b0, 1'b1, 4, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_reg("midrst_data", 1'b0, 32'h0000_0000);
    check_reg("midrst_status", 1'b1, 32'h0000_0000);
    send(8'hF0);
    check_reg("post_rst_data", 1'b0, 32'h0000_01F0);
    check_reg("post_rst_status", 1'b1, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2if.md
# ps2if

PS/2 keyboard receiver for the MicroBlaze MCS I/O bus, occupying bus bank PS2BANK (3'h3) beside the VGA interface. It samples the external PS/2 clock/data pair, deframes 11-bit device-to-host frames, checks parity and stop bit, and buffers valid scancodes in a FIFO. Firmware reads the FIFO and status through the BUSIF read-data mux (RDATA3) and pops or clears via bank writes (WR[PS2BANK]). The block is receive only and never drives the PS/2 lines.

## Interface
- FIFO_AW, 4: FIFO address width. Depth = 2**FIFO_AW = 16 entries.
- TIMEOUT, 50000: CLK cycles without a PS/2 falling edge before an in-progress frame is aborted (1 ms at 50 MHz).
- CLK  in  1  system clock, 50 MHz; the only clock.
- RST  in  1  synchronous, active-high reset.
- IO_Address  in  32  MCS I/O address. Only bit 2 is decoded; the bank is decoded by BUSIF.
- IO_Write_Data  in  32  MCS write data.
- WR  in  1  one-cycle bank write strobe from BUSIF.
- RDATA  out  32  read data to BUSIF; combinational from IO_Address[2] and internal registers.
- PS2CLK  in  1  raw PS/2 clock pin, asynchronous.
- PS2DATA  in  1  raw PS/2 data pin, asynchronous.

## Operation
- Input path: PS2CLK and PS2DATA each pass through a 2-FF synchronizer. A third register on the synchronized clock detects falling edges (previous 1, current 0).
- Receiver FSM states and transitions:
  - IDLE: on a falling edge with data=0 (start bit), go to DATA with bit count 0. A falling edge with data=1 is ignored.
  - DATA: shift in 8 bits, LSB first, one per falling edge. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: capture the stop bit, then go to IDLE.
- Frame acceptance is evaluated at the STOP edge:
  - Stop=1 and odd parity correct (XOR of data bits and parity bit = 1): push the byte.
  - Parity wrong: discard the byte and set PERR.
  - Stop=0: discard the byte and set FERR. If both errors occur, only FERR is set.
- Timeout: a counter runs in every state except IDLE and clears on each falling edge. When it reaches TIMEOUT, the FSM returns to IDLE, the partial byte is discarded and FERR is set.
- FIFO: 16 × 8 bits, with an FIFO_AW+1-bit count and wrap-around read/write pointers.
  - Push while full and no pop in the same cycle: the byte is dropped, FIFO contents are unchanged, and OVF is set.
  - Push and pop in the same cycle, at any fill level including full: both happen, the count is unchanged, no OVF.
  - Pop while empty: no effect.
- Register map, selected by IO_Address[2]:
  - 0, DATA:
    - Read: [7:0] = FIFO head (0x00 when empty), [8] = VALID (count≠0), [31:9] = 0. Reading is non-destructive.
    - Write (WR=1): pop one entry. Write data is ignored.
  - 1, STATUS:
    - Read: [4:0] = count (0..16), [8] = OVF, [9] = PERR, [10] = FERR, all other bits 0.
    - Write: for [10:8], each IO_Write_Data bit =1 clears the corresponding sticky flag. If a set event occurs in the same cycle as a clear, set wins.
- Reset: FSM to IDLE, shift register, bit count and timeout counter to 0, FIFO empty (pointers 0), all sticky flags 0, synchronizer and edge registers to 1 (line idle). After reset, RDATA reads 0x00000000 at both addresses.
- Reset asserted mid-frame: the partial frame is lost. The remaining bits of that frame are not misread as a new frame unless one of them is a 0 sampled while in IDLE; firmware tolerates this.

## Timing
- Edge detect latency: 3 CLK from a PS2CLK pin fall to the internal sample (2 sync + 1 edge register).
- The pushed byte is visible in RDATA (VALID=1) on the cycle after the STOP-edge sample cycle.
- A pop issued by WR in cycle N: RDATA shows the new head in N+1.
- A flag clear issued in cycle N: the flag reads 0 in N+1.
- RDATA has no registered delay and must be stable whenever IO_Address is stable; BUSIF registers it.
- A PS/2 bit period (60–100 µs) spans ≥3000 CLK, so at most one edge is processed per bit. No back-pressure exists toward the keyboard.

## Configuration
- PS2IF_GLITCH_FILTER_EN:
  - Defined: a 4-sample majority-free filter follows the synchronizer on PS2CLK. The filtered level changes only after 4 consecutive equal synchronized samples. Edge latency becomes 7 CLK, and pulses shorter than 4 CLK are rejected.
  - Undefined: no filter; latency is 3 CLK, and any synchronized fall is an edge.
  - Register map and frame behaviour are identical in both cases.

## Test plan
- Valid frame 0x1C (parity 0, stop 1) at 12 kHz → DATA reads 0x0000011C, STATUS reads 0x00000001. Pop, then DATA reads 0x00000000.
- 0x1C sent with parity 1 → count stays 0, STATUS 0x00000200. Write 0x200 to STATUS → STATUS 0x00000000.
- 17 frames 0x01..0x11 with no pop → STATUS 0x00000110, DATA head 0x101. 16 pops return 0x01..0x10 in order; 0x11 is lost.
- FIFO full, then a frame completes in the same cycle as a pop write → count stays 16, OVF stays 0, the last entry is the new byte.
- Start plus 5 data bits, then PS2CLK held high for >50000 CLK → STATUS 0x00000400. The next frame 0x29 is received as DATA 0x129.
- RST asserted for 1 cycle after 4 bits of a frame → all registers read 0, FSM in IDLE. The following clean frame 0xF0 (parity 1) → DATA 0x1F0.
